// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin sequencer for a shared combinational ALU
// Operands are registered toward the ALU; each result lands in a per-requester held response slot.
module alu_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid_i,
  output logic                  req0_ready_o,
  input  logic [OP_WIDTH-1:0]   req0_op_i,
  input  logic [DATA_WIDTH-1:0] req0_a_i,
  input  logic [DATA_WIDTH-1:0] req0_b_i,
  input  logic                  req1_valid_i,
  output logic                  req1_ready_o,
  input  logic [OP_WIDTH-1:0]   req1_op_i,
  input  logic [DATA_WIDTH-1:0] req1_a_i,
  input  logic [DATA_WIDTH-1:0] req1_b_i,
  output logic                  rsp0_valid_o,
  input  logic                  rsp0_ready_i,
  output logic [DATA_WIDTH-1:0] rsp0_result_o,
  output logic                  rsp0_zero_o,
  output logic                  rsp1_valid_o,
  input  logic                  rsp1_ready_i,
  output logic [DATA_WIDTH-1:0] rsp1_result_o,
  output logic                  rsp1_zero_o,
  output logic [OP_WIDTH-1:0]   alu_op_o,
  output logic [DATA_WIDTH-1:0] alu_a_o,
  output logic [DATA_WIDTH-1:0] alu_b_o,
  input  logic [DATA_WIDTH-1:0] alu_result_i,
  input  logic                  alu_zero_i,
  output logic                  busy_o
);

  typedef enum logic {IDLE, EXEC} state_t;

  state_t state;
  logic   last_grant;
  logic   owner;
  logic   elig0;
  logic   elig1;
  logic   grant;
  logic   accept0;
  logic   accept1;

  // A full response slot blocks its requester until consumed, even if ready arrives this cycle.
  always_comb begin
    elig0 = req0_valid_i && !rsp0_valid_o;
    elig1 = req1_valid_i && !rsp1_valid_o;
    grant = (elig0 && elig1) ? !last_grant : elig1;
  end

  assign req0_ready_o = (state == IDLE) && elig0 && !grant;
  assign req1_ready_o = (state == IDLE) && elig1 && grant;
  assign accept0      = req0_valid_i && req0_ready_o;
  assign accept1      = req1_valid_i && req1_ready_o;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      owner         <= 1'b0;
      busy_o        <= 1'b0;
      alu_op_o      <= '0;
      alu_a_o       <= '0;
      alu_b_o       <= '0;
      rsp0_valid_o  <= 1'b0;
      rsp0_result_o <= '0;
      rsp0_zero_o   <= 1'b0;
      rsp1_valid_o  <= 1'b0;
      rsp1_result_o <= '0;
      rsp1_zero_o   <= 1'b0;
    end else begin
      if (rsp0_ready_i) rsp0_valid_o <= 1'b0;
      if (rsp1_ready_i) rsp1_valid_o <= 1'b0;

      case (state)
        IDLE: begin
          if (accept0) begin
            alu_op_o   <= req0_op_i;
            alu_a_o    <= req0_a_i;
            alu_b_o    <= req0_b_i;
            owner      <= 1'b0;
            last_grant <= 1'b0;
            busy_o     <= 1'b1;
            state      <= EXEC;
          end else if (accept1) begin
            alu_op_o   <= req1_op_i;
            alu_a_o    <= req1_a_i;
            alu_b_o    <= req1_b_i;
            owner      <= 1'b1;
            last_grant <= 1'b1;
            busy_o     <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          // The owner's slot is known empty here, so the capture never overwrites a pending result.
          if (!owner) begin
            rsp0_valid_o  <= 1'b1;
            rsp0_result_o <= alu_result_i;
            rsp0_zero_o   <= alu_zero_i;
          end else begin
            rsp1_valid_o  <= 1'b1;
            rsp1_result_o <= alu_result_i;
            rsp1_zero_o   <= alu_zero_i;
          end
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter with a behavioural ALU
// Directed vectors push expected grants/results; a negedge monitor pops and compares.
module tb_alu_arbiter;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_ORI  = 4'h2;
  localparam logic [3:0] OP_SLLI = 4'h3;
  localparam logic [3:0] OP_SRLI = 4'h4;
  localparam logic [3:0] OP_LUI  = 4'h5;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_op = '0, req1_op = '0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [31:0] rsp0_result, rsp1_result;
  logic        rsp0_zero, rsp1_zero;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        alu_zero, busy;

  int n_cmp = 0;
  int n_fail = 0;
  int gq[$];
  logic [32:0] q0[$];
  logic [32:0] q1[$];

  always #5 clk = ~clk;

  always_comb begin
    case (alu_op)
      OP_ADD:  alu_result = alu_a + alu_b;
      OP_SUB:  alu_result = alu_a - alu_b;
      OP_ORI:  alu_result = alu_a | alu_b;
      OP_SLLI: alu_result = alu_a << alu_b[4:0];
      OP_SRLI: alu_result = alu_a >> alu_b[4:0];
      OP_LUI:  alu_result = alu_b;
      default: alu_result = 32'h0;
    endcase
    alu_zero = (alu_result == 32'h0);
  end

  alu_arbiter #(.DATA_WIDTH(32), .OP_WIDTH(4)) dut (
    .clk(clk), .reset(reset),
    .req0_valid_i(req0_valid), .req0_ready_o(req0_ready), .req0_op_i(req0_op),
    .req0_a_i(req0_a), .req0_b_i(req0_b),
    .req1_valid_i(req1_valid), .req1_ready_o(req1_ready), .req1_op_i(req1_op),
    .req1_a_i(req1_a), .req1_b_i(req1_b),
    .rsp0_valid_o(rsp0_valid), .rsp0_ready_i(rsp0_ready),
    .rsp0_result_o(rsp0_result), .rsp0_zero_o(rsp0_zero),
    .rsp1_valid_o(rsp1_valid), .rsp1_ready_i(rsp1_ready),
    .rsp1_result_o(rsp1_result), .rsp1_zero_o(rsp1_zero),
    .alu_op_o(alu_op), .alu_a_o(alu_a), .alu_b_o(alu_b),
    .alu_result_i(alu_result), .alu_zero_i(alu_zero), .busy_o(busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: grants and consumed responses are compared against the scoreboard queues.
  always @(negedge clk) begin
    if (reset) begin
      if (req0_valid && req0_ready) begin
        if (gq.size() == 0) check("unexpected_grant0", 64'd0, 64'd99);
        else check("grant_order", 64'd0, 64'(gq.pop_front()));
      end
      if (req1_valid && req1_ready) begin
        if (gq.size() == 0) check("unexpected_grant1", 64'd1, 64'd99);
        else check("grant_order", 64'd1, 64'(gq.pop_front()));
      end
      if (rsp0_valid && rsp0_ready) begin
        if (q0.size() == 0) check("unexpected_rsp0", {31'd0, rsp0_zero, rsp0_result}, 64'hdead);
        else check("rsp0", {31'd0, rsp0_zero, rsp0_result}, {31'd0, q0.pop_front()});
      end
      if (rsp1_valid && rsp1_ready) begin
        if (q1.size() == 0) check("unexpected_rsp1", {31'd0, rsp1_zero, rsp1_result}, 64'hdead);
        else check("rsp1", {31'd0, rsp1_zero, rsp1_result}, {31'd0, q1.pop_front()});
      end
    end
  end

  task automatic set_req(input int k, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    if (k == 0) begin
      req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
    end else begin
      req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
    end
  endtask

  task automatic wait_accepts(input int n);
    int got = 0;
    for (int i = 0; i < 100 && got < n; i++) begin
      @(negedge clk);
      if (req0_valid && req0_ready) got++;
      if (req1_valid && req1_ready) got++;
    end
    check("accept_count", 64'(got), 64'(n));
    @(posedge clk); #1;
  endtask

  task automatic send(input int k, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] res);
    gq.push_back(k);
    if (k == 0) q0.push_back({res == 32'h0, res});
    else q1.push_back({res == 32'h0, res});
    set_req(k, op, a, b);
    wait_accepts(1);
    if (k == 0) req0_valid = 1'b0;
    else req1_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int held;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rsp0_valid", 64'(rsp0_valid), 64'd0);
    check("rst_rsp1_valid", 64'(rsp1_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_alu", {28'd0, alu_op, alu_a}, 64'd0);
    check("rst_ready", {62'd0, req0_ready, req1_ready}, 64'd0);
    @(posedge clk); #1 reset = 1'b1;

    // Tie right after reset: req0 first, then forced alternation through full slots.
    gq.push_back(0); gq.push_back(1); gq.push_back(0); gq.push_back(1);
    q0.push_back({1'b1, 32'h0}); q0.push_back({1'b1, 32'h0});
    q1.push_back({1'b0, 32'hFF}); q1.push_back({1'b0, 32'hFF});
    set_req(0, OP_SUB, 32'd9, 32'd9);
    set_req(1, OP_ORI, 32'hF0, 32'h0F);
    wait_accepts(4);
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain(4);

    // Single request latency and busy width.
    send(0, OP_ADD, 32'd5, 32'd7, 32'd12);
    @(negedge clk);
    check("lat_busy_exec", 64'(busy), 64'd1);
    check("lat_rsp_exec", 64'(rsp0_valid), 64'd0);
    @(negedge clk);
    check("lat_busy_after", 64'(busy), 64'd0);
    check("lat_rsp_after", 64'(rsp0_valid), 64'd1);
    drain(3);

    // Real tie with last_grant=0: req1 wins.
    gq.push_back(1); gq.push_back(0);
    q1.push_back({1'b0, 32'h20});
    q0.push_back({1'b0, 32'h12345000});
    set_req(0, OP_LUI, 32'h0, 32'h12345000);
    set_req(1, OP_SLLI, 32'h1, 32'h25);
    wait_accepts(2);
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain(4);

    // Backpressure on rsp0: req1 served, rsp0 held stable.
    rsp0_ready = 1'b0;
    send(0, OP_ADD, 32'd1, 32'd2, 32'd3);
    gq.push_back(1); gq.push_back(0);
    q1.push_back({1'b0, 32'h1});
    q0.push_back({1'b0, 32'd7});
    set_req(0, OP_SUB, 32'd10, 32'd3);
    set_req(1, OP_SRLI, 32'h80000000, 32'd31);
    wait_accepts(1);
    req1_valid = 1'b0;
    held = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp0_valid && rsp0_result == 32'd3 && !req0_ready) held++;
    end
    check("bp_hold_cycles", 64'(held), 64'd4);
    @(posedge clk); #1 rsp0_ready = 1'b1;
    wait_accepts(1);
    req0_valid = 1'b0;
    drain(4);

    send(1, 4'hF, 32'h1234, 32'h5678, 32'h0);
    drain(4);

    // Reset during EXEC drops the in-flight op.
    gq.push_back(0);
    set_req(0, OP_ADD, 32'd5, 32'd7);
    wait_accepts(1);
    reset = 1'b0; req0_valid = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_rsp", {62'd0, rsp0_valid, rsp1_valid}, 64'd0);
    check("mid_rst_alu", {28'd0, alu_op, alu_a}, 64'd0);
    drain(2);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_no_rsp", {62'd0, rsp0_valid, rsp1_valid}, 64'd0);
    @(posedge clk); #1;
    gq.push_back(0); gq.push_back(1);
    q0.push_back({1'b0, 32'd5});
    q1.push_back({1'b0, 32'h101});
    set_req(0, OP_ADD, 32'd2, 32'd3);
    set_req(1, OP_ORI, 32'h100, 32'h1);
    wait_accepts(2);
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain(6);

    check("gq_empty", 64'(gq.size()), 64'd0);
    check("q0_empty", 64'(q0.size()), 64'd0);
    check("q1_empty", 64'(q1.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
